sh_ctrl: RTL and testbench

SH_CTRL -- requirements
Module: sh_ctrl

---
 rtl/sh_ctrl.sv | 118 +++++++++++
 tb/tb_sh_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sh_ctrl.sv
// Shift-register datapath controller: accepts a word, strobes one parallel load,
// then WIDTH shift enables, then GAP idle cycles, with hold, abort and async reset.
module sh_ctrl #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       hold,
    input  logic                       abort,
    output logic                       lden,
    output logic                       shen,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [$clog2(WIDTH+1)-1:0] cnt
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CFULL = CW'(WIDTH);
    localparam logic [2:0]    GLAST = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt_nx;
    logic [2:0]    gcnt, gcnt_nx;
    logic          armed;

    // armed keeps req_ready low until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            gcnt  <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            gcnt  <= gcnt_nx;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        gcnt_nx   = gcnt;
        req_ready = 1'b0;
        lden      = 1'b0;
        shen      = 1'b0;
        done      = 1'b0;
        aborted   = 1'b0;
        busy      = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                req_ready = armed && !abort;
                cnt_nx    = '0;
                gcnt_nx   = '0;
                if (req_valid && armed && !abort) state_nx = S_LOAD;
            end
            S_LOAD: begin
                lden     = 1'b1;
                cnt_nx   = '0;
                state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                if (!hold) begin
                    shen = 1'b1;
                    if (cnt == CLAST) begin
                        done    = 1'b1;
                        gcnt_nx = '0;
                        if (GAP > 0) begin
                            state_nx = S_GAP;
                            cnt_nx   = CFULL;
                        end else begin
                            state_nx = S_IDLE;
                            cnt_nx   = '0;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gcnt == GLAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                    gcnt_nx  = '0;
                end else begin
                    gcnt_nx = gcnt + 3'd1;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // abort overrides hold and the final-shift completion
        if (abort && state != S_IDLE) begin
            lden     = 1'b0;
            shen     = 1'b0;
            done     = 1'b0;
            aborted  = 1'b1;
            state_nx = S_IDLE;
            cnt_nx   = '0;
            gcnt_nx  = '0;
        end
    end

endmodule

// File: tb/tb_sh_ctrl.sv
// Bench for sh_ctrl (WIDTH=4, GAP=1): directed vector table, back-to-back
// spacing sequence, and random stimulus against a schedule-based model.
module tb_sh_ctrl;

    localparam int WIDTH = 4;
    localparam int GAP   = 1;
    localparam int CW    = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0, hold = 1'b0, abort = 1'b0;
    logic req_ready, lden, shen, busy, done, aborted;
    logic [CW-1:0] cnt;

    int nvec = 0;
    int nbad = 0;

    sh_ctrl #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .hold(hold), .abort(abort), .lden(lden), .shen(shen), .busy(busy),
        .done(done), .aborted(aborted), .cnt(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          r, v, h, a;
        logic [5+CW:0] exp;   // {rdy, ld, sh, bz, dn, ab, cnt}
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, v, h, a, rdy, ld, sh, bz, dn, ab, input int c);
        vec_t t;
        t.r = r; t.v = v; t.h = h; t.a = a;
        t.exp = {rdy, ld, sh, bz, dn, ab, CW'(c)};
        tbl.push_back(t);
    endtask

    task automatic drive(input logic r, v, h, a);
        @(negedge clk);
        rst_n = r; req_valid = v; hold = h; abort = a;
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [5+CW:0] exp);
        logic [5+CW:0] got;
        got = {req_ready, lden, shen, busy, done, aborted, cnt};
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s[%0d] t=%0t {rdy,ld,sh,bz,dn,ab,cnt}: got %b required %b",
                     name, idx, $time, got, exp);
        end
    endtask

    // Model: a word is a schedule of one load, WIDTH shifts, GAP idle cycles
    bit m_seen, m_active;
    int m_shifts;   // -1 while the load is pending, else shifts completed
    int m_gapl;

    task automatic m_reset();
        m_seen = 0; m_active = 0; m_shifts = 0; m_gapl = 0;
    endtask

    function automatic logic [5+CW:0] m_out(input logic v, h, a);
        logic rdy, ld, sh, dn, ab;
        int c;
        rdy = !m_active && !a && m_seen;
        ld  = m_active && m_shifts < 0 && !a;
        sh  = m_active && m_shifts >= 0 && m_shifts < WIDTH && !h && !a;
        dn  = sh && m_shifts == WIDTH - 1;
        ab  = m_active && a;
        c   = (m_active && m_shifts > 0) ? m_shifts : 0;
        return {rdy, ld, sh, m_active, dn, ab, CW'(c)};
    endfunction

    task automatic m_step(input logic v, h, a);
        logic [5+CW:0] o;
        o = m_out(v, h, a);
        m_seen = 1;
        if (o[CW]) m_active = 0;
        else if (!m_active) begin
            if (v && o[5+CW]) begin m_active = 1; m_shifts = -1; end
        end else if (m_shifts < 0) m_shifts = 0;
        else if (o[3+CW]) begin
            m_shifts++;
            if (m_shifts == WIDTH) begin
                if (GAP == 0) m_active = 0;
                else m_gapl = GAP;
            end
        end else if (m_shifts == WIDTH) begin
            m_gapl--;
            if (m_gapl == 0) m_active = 0;
        end
    endtask

    initial begin
        int acc[$];
        bit overlap;
        // reset and release
        add(0,0,0,0, 0,0,0,0,0,0,0);
        add(0,1,0,0, 0,0,0,0,0,0,0);
        add(1,0,0,0, 0,0,0,0,0,0,0);
        add(1,0,0,0, 1,0,0,0,0,0,0);
        // single word
        add(1,1,0,0, 1,0,0,0,0,0,0);
        add(1,0,0,0, 0,1,0,1,0,0,0);
        add(1,0,0,0, 0,0,1,1,0,0,0);
        add(1,0,0,0, 0,0,1,1,0,0,1);
        add(1,0,0,0, 0,0,1,1,0,0,2);
        add(1,0,0,0, 0,0,1,1,1,0,3);
        add(1,0,0,0, 0,0,0,1,0,0,4);
        add(1,0,0,0, 1,0,0,0,0,0,0);
        // hold on 2nd shift for 2 cycles; hold ignored in LOAD and GAP
        add(1,1,0,0, 1,0,0,0,0,0,0);
        add(1,0,1,0, 0,1,0,1,0,0,0);
        add(1,0,0,0, 0,0,1,1,0,0,0);
        add(1,0,1,0, 0,0,0,1,0,0,1);
        add(1,0,1,0, 0,0,0,1,0,0,1);
        add(1,0,0,0, 0,0,1,1,0,0,1);
        add(1,0,0,0, 0,0,1,1,0,0,2);
        add(1,0,0,0, 0,0,1,1,1,0,3);
        add(1,0,1,0, 0,0,0,1,0,0,4);
        add(1,0,0,0, 1,0,0,0,0,0,0);
        // abort on 3rd shift
        add(1,1,0,0, 1,0,0,0,0,0,0);
        add(1,0,0,0, 0,1,0,1,0,0,0);
        add(1,0,0,0, 0,0,1,1,0,0,0);
        add(1,0,0,0, 0,0,1,1,0,0,1);
        add(1,0,0,1, 0,0,0,1,0,1,2);
        add(1,0,0,0, 1,0,0,0,0,0,0);
        // abort with hold on the final shift: no done
        add(1,1,0,0, 1,0,0,0,0,0,0);
        add(1,0,0,0, 0,1,0,1,0,0,0);
        add(1,0,0,0, 0,0,1,1,0,0,0);
        add(1,0,0,0, 0,0,1,1,0,0,1);
        add(1,0,0,0, 0,0,1,1,0,0,2);
        add(1,0,1,1, 0,0,0,1,0,1,3);
        add(1,0,0,0, 1,0,0,0,0,0,0);
        // abort in LOAD
        add(1,1,0,0, 1,0,0,0,0,0,0);
        add(1,0,0,1, 0,0,0,1,0,1,0);
        add(1,0,0,0, 1,0,0,0,0,0,0);
        // abort in GAP
        add(1,1,0,0, 1,0,0,0,0,0,0);
        add(1,0,0,0, 0,1,0,1,0,0,0);
        add(1,0,0,0, 0,0,1,1,0,0,0);
        add(1,0,0,0, 0,0,1,1,0,0,1);
        add(1,0,0,0, 0,0,1,1,0,0,2);
        add(1,0,0,0, 0,0,1,1,1,0,3);
        add(1,0,0,1, 0,0,0,1,0,1,4);
        add(1,0,0,0, 1,0,0,0,0,0,0);
        // abort with req_valid in IDLE: no accept, no aborted
        add(1,1,0,1, 0,0,0,0,0,0,0);
        add(1,0,0,0, 1,0,0,0,0,0,0);
        add(1,0,0,0, 1,0,0,0,0,0,0);
        // async reset mid-SHIFT, then release: no done afterwards
        add(1,1,0,0, 1,0,0,0,0,0,0);
        add(1,0,0,0, 0,1,0,1,0,0,0);
        add(1,0,0,0, 0,0,1,1,0,0,0);
        add(1,0,0,0, 0,0,1,1,0,0,1);
        add(0,0,0,0, 0,0,0,0,0,0,0);
        add(0,1,0,0, 0,0,0,0,0,0,0);
        add(1,0,0,0, 0,0,0,0,0,0,0);
        add(1,0,0,0, 1,0,0,0,0,0,0);
        add(1,0,0,0, 1,0,0,0,0,0,0);
        add(1,0,0,0, 1,0,0,0,0,0,0);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].h, tbl[i].a);
            check("tbl", i, tbl[i].exp);
        end

        // back-to-back: accepts exactly 1+WIDTH+GAP+1 cycles apart
        overlap = 0;
        for (int c = 0; c < 30; c++) begin
            drive(1, 1, 0, 0);
            if (req_ready) acc.push_back(c);
            if (lden && shen) overlap = 1;
        end
        drive(1, 0, 0, 0);
        nvec++;
        if (acc.size() != 5) begin
            nbad++;
            $display("FAIL b2b_count: got %0d accepts required 5", acc.size());
        end
        for (int k = 1; k < acc.size(); k++) begin
            nvec++;
            if (acc[k] - acc[k-1] != 1 + WIDTH + GAP + 1) begin
                nbad++;
                $display("FAIL b2b_spacing[%0d]: got %0d required %0d",
                         k, acc[k] - acc[k-1], 1 + WIDTH + GAP + 1);
            end
        end
        nvec++;
        if (overlap) begin
            nbad++;
            $display("FAIL b2b_overlap: got lden&shen=1 required 0");
        end

        // random stimulus against the model
        for (int n = 0; n < 600; n++) begin
            logic r, v, h, a;
            r = (n == 0) ? 1'b0 : ($urandom_range(99) != 0);
            v = ($urandom_range(9) < 7);
            h = ($urandom_range(3) == 0);
            a = ($urandom_range(19) == 0);
            drive(r, v, h, a);
            if (!r) m_reset();
            check("rand", n, m_out(v, h, a));
            @(posedge clk);
            if (r) m_step(v, h, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
